// File: rtl/id_stage_pkg.sv
// RV32I decode definitions shared by the ID stage and the EX-stage ALU control.
package id_stage_pkg;
    localparam int NB_ADDR = 32;
    localparam int NB_WORD = 32;
    localparam int NREG    = 32;
    localparam int NB_REG  = $clog2(NREG);

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    typedef struct packed {
        logic [NB_ADDR-1:0] pc;
        logic [NB_ADDR-1:0] next_pc;
        logic [NB_WORD-1:0] rs1_data;
        logic [NB_WORD-1:0] rs2_data;
        logic [NB_WORD-1:0] imm;
        logic [NB_REG-1:0]  rs1;
        logic [NB_REG-1:0]  rs2;
        logic [NB_REG-1:0]  rd;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic               funct7b5;
        logic               illegal;
        logic               valid;
    } id_ex_t;

    // Opcodes outside the supported set map to IMM_NONE and are flagged illegal by the caller.
    function automatic imm_type_e imm_type_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_OP_IMM, OP_JALR: return IMM_I;
            OP_STORE:                    return IMM_S;
            OP_BRANCH:                   return IMM_B;
            OP_LUI, OP_AUIPC:            return IMM_U;
            OP_JAL:                      return IMM_J;
            default:                     return IMM_NONE;
        endcase
    endfunction
endpackage

// File: rtl/id_stage_pipe_reg.sv
// Generic pipeline register: enable, synchronous clear, async active-low reset.
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en) q_d = clr ? '0 : d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/id_stage_reg_file.sv
// Register file: 2 combinational read ports with write-through bypass, 1 write port, x0 hardwired to 0.
module reg_file #(
    parameter int NREG    = 32,
    parameter int NB_WORD = 32,
    parameter int NB_REG  = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NB_REG-1:0]  waddr,
    input  logic [NB_WORD-1:0] wdata,
    input  logic [NB_REG-1:0]  raddr1,
    input  logic [NB_REG-1:0]  raddr2,
    output logic [NB_WORD-1:0] rdata1,
    output logic [NB_WORD-1:0] rdata2
);
    logic [NB_WORD-1:0] regs_q [NREG];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (raddr1 == '0)                      rdata1 = '0;
        else if (we && waddr == raddr1)        rdata1 = wdata;
        if (raddr2 == '0)                      rdata2 = '0;
        else if (we && waddr == raddr2)        rdata2 = wdata;
    end
endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file, immediate generation and the ID_EX pipeline register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_n,
    input  logic                flush,
    input  logic [NB_WORD-1:0]  instr,
    input  logic [NB_ADDR-1:0]  if_id_pc,
    input  logic [NB_ADDR-1:0]  if_id_nextPc,
    input  logic                wb_regWrite,
    input  logic [NB_REG-1:0]   wb_rd,
    input  logic [NB_WORD-1:0]  wb_data,
    output logic [NB_REG-1:0]   id_rs1,
    output logic [NB_REG-1:0]   id_rs2,
    output logic [NB_ADDR-1:0]  id_ex_pc,
    output logic [NB_ADDR-1:0]  id_ex_nextPc,
    output logic [NB_WORD-1:0]  id_ex_rs1Data,
    output logic [NB_WORD-1:0]  id_ex_rs2Data,
    output logic [NB_WORD-1:0]  id_ex_imm,
    output logic [NB_REG-1:0]   id_ex_rs1,
    output logic [NB_REG-1:0]   id_ex_rs2,
    output logic [NB_REG-1:0]   id_ex_rd,
    output logic [6:0]          id_ex_opcode,
    output logic [2:0]          id_ex_funct3,
    output logic                id_ex_funct7b5,
    output logic                id_ex_illegal,
    output logic                id_ex_valid
);
    logic               warm_q, warm_d;
    logic [NB_WORD-1:0] rs1_data, rs2_data;
    id_ex_t             id_ex_d, id_ex_q;
    imm_type_e          itype;

    assign id_rs1 = instr[19:15];
    assign id_rs2 = instr[24:20];

    reg_file #(.NREG(NREG), .NB_WORD(NB_WORD)) u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_regWrite),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (id_rs1),
        .raddr2 (id_rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        itype            = imm_type_of(instr[6:0]);
        id_ex_d          = '0;
        id_ex_d.pc       = if_id_pc;
        id_ex_d.next_pc  = if_id_nextPc;
        id_ex_d.rs1_data = rs1_data;
        id_ex_d.rs2_data = rs2_data;
        id_ex_d.rs1      = instr[19:15];
        id_ex_d.rs2      = instr[24:20];
        id_ex_d.rd       = instr[11:7];
        id_ex_d.opcode   = instr[6:0];
        id_ex_d.funct3   = instr[14:12];
        id_ex_d.funct7b5 = instr[30];
        id_ex_d.valid    = warm_q;
        case (itype)
            IMM_I:   id_ex_d.imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   id_ex_d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   id_ex_d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   id_ex_d.imm = {instr[31:12], 12'b0};
            IMM_J:   id_ex_d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: id_ex_d.imm = '0;
        endcase
        // OP, MISC-MEM and SYSTEM carry no immediate but are still legal.
        id_ex_d.illegal = (itype == IMM_NONE) && !(instr[6:0] == OP_OP ||
                          instr[6:0] == OP_MISC_MEM || instr[6:0] == OP_SYSTEM);
    end

    pipe_reg #(.WIDTH($bits(id_ex_t))) u_id_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_n | flush),
        .clr   (flush),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    assign warm_d = warm_q | stall_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) warm_q <= 1'b0;
        else        warm_q <= warm_d;
    end

    assign id_ex_pc       = id_ex_q.pc;
    assign id_ex_nextPc   = id_ex_q.next_pc;
    assign id_ex_rs1Data  = id_ex_q.rs1_data;
    assign id_ex_rs2Data  = id_ex_q.rs2_data;
    assign id_ex_imm      = id_ex_q.imm;
    assign id_ex_rs1      = id_ex_q.rs1;
    assign id_ex_rs2      = id_ex_q.rs2;
    assign id_ex_rd       = id_ex_q.rd;
    assign id_ex_opcode   = id_ex_q.opcode;
    assign id_ex_funct3   = id_ex_q.funct3;
    assign id_ex_funct7b5 = id_ex_q.funct7b5;
    assign id_ex_illegal  = id_ex_q.illegal;
    assign id_ex_valid    = id_ex_q.valid;
endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the ID stage.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall_n, flush, wb_regWrite;
    logic [31:0] instr, if_id_pc, if_id_nextPc, wb_data;
    logic [4:0]  wb_rd;
    logic [4:0]  id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [31:0] id_ex_pc, id_ex_nextPc, id_ex_rs1Data, id_ex_rs2Data, id_ex_imm;
    logic [6:0]  id_ex_opcode;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5, id_ex_illegal, id_ex_valid;

    int checks = 0;
    int failures = 0;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_n(stall_n), .flush(flush), .instr(instr),
        .if_id_pc(if_id_pc), .if_id_nextPc(if_id_nextPc), .wb_regWrite(wb_regWrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ex_pc(id_ex_pc), .id_ex_nextPc(id_ex_nextPc), .id_ex_rs1Data(id_ex_rs1Data),
        .id_ex_rs2Data(id_ex_rs2Data), .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1),
        .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_opcode(id_ex_opcode),
        .id_ex_funct3(id_ex_funct3), .id_ex_funct7b5(id_ex_funct7b5),
        .id_ex_illegal(id_ex_illegal), .id_ex_valid(id_ex_valid)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins, input logic [31:0] pc);
        instr = ins;
        if_id_pc = pc;
        if_id_nextPc = pc + 32'd4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_n = 1'b1; flush = 1'b0; wb_regWrite = 1'b0;
        wb_rd = '0; wb_data = '0;
        set_instr(32'h0000_0013, 32'h0);
        #12;
        checks++;
        if ({id_ex_pc, id_ex_imm, id_ex_rs1Data, id_ex_rd, id_ex_valid} !== '0) begin
            failures++; $display("FAIL reset_state got pc=%h imm=%h valid=%b, expected all 0", id_ex_pc, id_ex_imm, id_ex_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        // First edge out of reset captures a bubble (warm flag not yet earned).
        tick();
        checks++;
        if (id_ex_valid !== 1'b0 || id_ex_pc !== 32'h0) begin
            failures++; $display("FAIL first_capture_valid got valid=%b pc=%h, expected valid=0 pc=0", id_ex_valid, id_ex_pc);
        end
    endtask

    task automatic test_wb_bypass();
        set_instr(32'hFFF2_8313, 32'h0000_0100);
        wb_regWrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (id_rs1 !== 5'd5 || id_rs2 !== 5'd31) begin
            failures++; $display("FAIL comb_rs_idx got rs1=%0d rs2=%0d, expected 5 31", id_rs1, id_rs2);
        end
        tick();
        wb_regWrite = 1'b0;
        checks++;
        if (id_ex_rs1Data !== 32'hDEAD_BEEF || id_ex_imm !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL bypass_addi got rs1Data=%h imm=%h, expected deadbeef ffffffff", id_ex_rs1Data, id_ex_imm);
        end
        checks++;
        if (id_ex_rd !== 5'd6 || id_ex_valid !== 1'b1 || id_ex_pc !== 32'h100 || id_ex_nextPc !== 32'h104 || id_ex_opcode !== 7'h13) begin
            failures++; $display("FAIL addi_fields got rd=%0d valid=%b pc=%h npc=%h op=%h, expected 6 1 100 104 13",
                                 id_ex_rd, id_ex_valid, id_ex_pc, id_ex_nextPc, id_ex_opcode);
        end
    endtask

    task automatic test_x0_and_storage();
        set_instr(32'h0050_0093, 32'h0000_0104);   // addi x1,x0,5
        wb_regWrite = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
        tick();
        checks++;
        if (id_ex_rs1Data !== 32'h0 || id_ex_imm !== 32'h5) begin
            failures++; $display("FAIL x0_write_dropped got rs1Data=%h imm=%h, expected 0 5", id_ex_rs1Data, id_ex_imm);
        end
        wb_rd = 5'd7; wb_data = 32'hCAFE_0001;
        tick();
        wb_regWrite = 1'b0;
        set_instr(32'h0053_8433, 32'h0000_0108);   // add x8,x7,x5
        tick();
        checks++;
        if (id_ex_rs1Data !== 32'hCAFE_0001 || id_ex_rs2Data !== 32'hDEAD_BEEF || id_ex_imm !== 32'h0 || id_ex_illegal !== 1'b0) begin
            failures++; $display("FAIL regfile_read got rs1=%h rs2=%h imm=%h ill=%b, expected cafe0001 deadbeef 0 0",
                                 id_ex_rs1Data, id_ex_rs2Data, id_ex_imm, id_ex_illegal);
        end
    endtask

    task automatic test_imm_forms();
        logic [31:0] vec [4];
        logic [31:0] exp [4];
        vec = '{32'hFE20_AE23, 32'hFE00_0CE3, 32'h0010_00EF, 32'h1234_51B7};
        exp = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0800, 32'h1234_5000};
        for (int i = 0; i < 4; i++) begin
            set_instr(vec[i], 32'h200 + 32'(i * 4));
            tick();
            checks++;
            if (id_ex_imm !== exp[i] || id_ex_valid !== 1'b1) begin
                failures++; $display("FAIL imm_form_%0d instr=%h got imm=%h valid=%b, expected %h 1", i, vec[i], id_ex_imm, id_ex_valid, exp[i]);
            end
        end
        checks++;
        if (id_ex_rd !== 5'd3) begin
            failures++; $display("FAIL lui_rd got %0d expected 3", id_ex_rd);
        end
        set_instr(32'h0010_00EF, 32'h300);
        tick();
        checks++;
        if (id_ex_rd !== 5'd1 || id_ex_opcode !== 7'h6F) begin
            failures++; $display("FAIL jal_rd got rd=%0d op=%h expected 1 6f", id_ex_rd, id_ex_opcode);
        end
    endtask

    task automatic test_stall_flush();
        set_instr(32'h1234_51B7, 32'h400);
        tick();
        stall_n = 1'b0;
        set_instr(32'hFFF2_8313, 32'h404);
        tick();
        set_instr(32'hFE20_AE23, 32'h408);
        tick();
        checks++;
        if (id_ex_imm !== 32'h1234_5000 || id_ex_pc !== 32'h400 || id_ex_rd !== 5'd3 || id_ex_valid !== 1'b1) begin
            failures++; $display("FAIL stall_hold got imm=%h pc=%h rd=%0d valid=%b, expected 12345000 400 3 1",
                                 id_ex_imm, id_ex_pc, id_ex_rd, id_ex_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({id_ex_pc, id_ex_nextPc, id_ex_imm, id_ex_rs1Data, id_ex_rs2Data, id_ex_rd, id_ex_opcode, id_ex_funct3, id_ex_valid} !== '0) begin
            failures++; $display("FAIL flush_over_stall got pc=%h imm=%h op=%h valid=%b, expected all 0",
                                 id_ex_pc, id_ex_imm, id_ex_opcode, id_ex_valid);
        end
        stall_n = 1'b1;
    endtask

    task automatic test_illegal();
        set_instr(32'h0000_007F, 32'h500);
        tick();
        checks++;
        if (id_ex_illegal !== 1'b1 || id_ex_imm !== 32'h0 || id_ex_valid !== 1'b1) begin
            failures++; $display("FAIL illegal_op got ill=%b imm=%h valid=%b, expected 1 0 1", id_ex_illegal, id_ex_imm, id_ex_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        set_instr(32'h0053_8433, 32'h600);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({id_ex_pc, id_ex_rs1Data, id_ex_rs2Data, id_ex_opcode, id_ex_valid} !== '0) begin
            failures++; $display("FAIL async_reset got pc=%h rs1=%h op=%h valid=%b, expected all 0", id_ex_pc, id_ex_rs1Data, id_ex_opcode, id_ex_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        checks++;
        if (id_ex_rs1Data !== 32'h0 || id_ex_rs2Data !== 32'h0 || id_ex_valid !== 1'b0 || id_ex_pc !== 32'h600) begin
            failures++; $display("FAIL post_reset_capture got rs1=%h rs2=%h valid=%b pc=%h, expected 0 0 0 600",
                                 id_ex_rs1Data, id_ex_rs2Data, id_ex_valid, id_ex_pc);
        end
        tick();
        checks++;
        if (id_ex_valid !== 1'b1) begin
            failures++; $display("FAIL warm_reearned got valid=%b expected 1", id_ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_x0_and_storage();
        test_imm_forms();
        test_stall_flush();
        test_illegal();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
